// File: rtl/viterbi_decoder_k3_pkg.sv
// rtl/viterbi_decoder_k3_pkg.sv - shared trellis constants and symbol helpers for the K=3 Viterbi decoder
package viterbi_decoder_k3_pkg;

  localparam int N_STATES = 4;
  localparam int K_LEN = 3;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  // State is {D0, D1}; the generator taps line up with {b, D0, D1}.
  function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic b);
    logic [K_LEN-1:0] w_taps;
    w_taps = {b, state};
    return {^(w_taps & G1), ^(w_taps & G0)};
  endfunction

  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] state,
                                               input logic b);
    logic [1:0] w_diff;
    w_diff = rx ^ exp_sym(state, b);
    return {w_diff[1] & w_diff[0], w_diff[1] ^ w_diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_decoder_k3_acs.sv
// rtl/viterbi_decoder_k3_acs.sv - add-compare-select for one trellis state with saturating metrics
module viterbi_acs #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 5
) (
  input  logic [PM_W-1:0]     i_pm0,
  input  logic [PM_W-1:0]     i_pm1,
  input  logic [1:0]          i_bm0,
  input  logic [1:0]          i_bm1,
  input  logic [TB_DEPTH-1:0] i_surv0,
  input  logic [TB_DEPTH-1:0] i_surv1,
  input  logic                i_bit,
  output logic [PM_W-1:0]     o_pm,
  output logic [TB_DEPTH-1:0] o_surv
);

  logic [PM_W:0]       w_sum0;
  logic [PM_W:0]       w_sum1;
  logic [PM_W-1:0]     w_sat0;
  logic [PM_W-1:0]     w_sat1;
  logic                w_sel1;
  logic [TB_DEPTH-1:0] w_surv;

  assign w_sum0 = {1'b0, i_pm0} + {{(PM_W-1){1'b0}}, i_bm0};
  assign w_sum1 = {1'b0, i_pm1} + {{(PM_W-1){1'b0}}, i_bm1};
  assign w_sat0 = w_sum0[PM_W] ? {PM_W{1'b1}} : w_sum0[PM_W-1:0];
  assign w_sat1 = w_sum1[PM_W] ? {PM_W{1'b1}} : w_sum1[PM_W-1:0];

  // Strict less-than so equal metrics keep the {x,0} predecessor.
  assign w_sel1 = (w_sat1 < w_sat0);
  assign w_surv = w_sel1 ? i_surv1 : i_surv0;
  assign o_pm   = w_sel1 ? w_sat1 : w_sat0;
  assign o_surv = {w_surv[TB_DEPTH-2:0], i_bit};

endmodule

// File: rtl/viterbi_decoder_k3.sv
// rtl/viterbi_decoder_k3.sv - rate-1/2 K=3 hard-decision Viterbi decoder with register-exchange survivors
module viterbi_decoder_k3
  import viterbi_decoder_k3_pkg::*;
#(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] c,
  input  logic       sof,
  output logic       out_valid,
  output logic       out_bit
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

  logic [PM_W-1:0]     r_pm   [N_STATES];
  logic [TB_DEPTH-1:0] r_surv [N_STATES];
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic                r_out_bit;

  logic [PM_W-1:0]     w_pm_src   [N_STATES];
  logic [TB_DEPTH-1:0] w_surv_src [N_STATES];
  logic [PM_W-1:0]     w_acs_pm   [N_STATES];
  logic [TB_DEPTH-1:0] w_acs_surv [N_STATES];
  logic [PM_W-1:0]     w_pm_norm  [N_STATES];
  logic [PM_W-1:0]     w_min;
  logic [1:0]          w_dec;
  logic [CNT_W-1:0]    w_k;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_emit;

  // A start-of-frame symbol runs ACS from the initial metrics instead of the held ones.
  always_comb begin
    for (int i = 0; i < N_STATES; i++) begin
      w_pm_src[i]   = sof ? ((i == 0) ? '0 : PM_MAX) : r_pm[i];
      w_surv_src[i] = sof ? '0 : r_surv[i];
    end
  end

  for (genvar s = 0; s < N_STATES; s++) begin : g_acs
    localparam int   P0 = (s % 2) * 2;
    localparam int   P1 = P0 + 1;
    localparam logic B  = (s >= 2);

    logic [1:0] w_bm0;
    logic [1:0] w_bm1;

    assign w_bm0 = branch_metric(c, 2'(P0), B);
    assign w_bm1 = branch_metric(c, 2'(P1), B);

    viterbi_acs #(
      .TB_DEPTH (TB_DEPTH),
      .PM_W     (PM_W)
    ) u_acs (
      .i_pm0   (w_pm_src[P0]),
      .i_pm1   (w_pm_src[P1]),
      .i_bm0   (w_bm0),
      .i_bm1   (w_bm1),
      .i_surv0 (w_surv_src[P0]),
      .i_surv1 (w_surv_src[P1]),
      .i_bit   (B),
      .o_pm    (w_acs_pm[s]),
      .o_surv  (w_acs_surv[s])
    );
  end

  always_comb begin
    w_min = w_acs_pm[0];
    w_dec = 2'd0;
    for (int i = 1; i < N_STATES; i++) begin
      if (w_acs_pm[i] < w_min) begin
        w_min = w_acs_pm[i];
        w_dec = 2'(i);
      end
    end
    for (int i = 0; i < N_STATES; i++) begin
      w_pm_norm[i] = w_acs_pm[i] - w_min;
    end
  end

  assign w_k        = sof ? '0 : r_cnt;
  assign w_emit     = (w_k >= CNT_W'(TB_DEPTH - 1));
  assign w_cnt_next = (w_k == CNT_W'(TB_DEPTH)) ? w_k : w_k + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_STATES; i++) begin
        r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
        r_surv[i] <= '0;
      end
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
    end else begin
      r_out_valid <= in_valid && w_emit;
      if (in_valid) begin
        r_pm      <= w_pm_norm;
        r_surv    <= w_acs_surv;
        r_cnt     <= w_cnt_next;
        r_out_bit <= w_acs_surv[w_dec][TB_DEPTH-1];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// tb/tb_viterbi_decoder_k3.sv - directed self-checking bench for viterbi_decoder_k3
module tb_viterbi_decoder_k3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] c;
  logic       sof;
  logic       out_valid;
  logic       out_bit;

  int errors = 0;
  int checks = 0;

  logic [1:0] stim [64];
  logic       stim_sof [64];
  int         gap_after [64];
  logic       exp_bits [6];
  logic       dec [$];
  int         dec_k [$];
  int         gap_pulses;

  viterbi_decoder_k3 #(.TB_DEPTH(15), .PM_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .c         (c),
    .sof       (sof),
    .out_valid (out_valid),
    .out_bit   (out_bit)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [1:0] cv, input logic s,
                      output logic ov, output logic ob);
    @(negedge clk);
    in_valid = v;
    c        = cv;
    sof      = s;
    @(posedge clk);
    #1;
    ov = out_valid;
    ob = out_bit;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      stim[i]      = 2'b00;
      stim_sof[i]  = 1'b0;
      gap_after[i] = 0;
    end
  endtask

  // Bits 1,0,1,1,0,0 encoded from state 0, then 14 zero tail symbols.
  task automatic load_ref(input logic flip, input logic with_sof);
    clear_stim();
    stim[0] = 2'b11;
    stim[1] = 2'b01;
    stim[2] = flip ? 2'b01 : 2'b00;
    stim[3] = 2'b10;
    stim[4] = 2'b10;
    stim[5] = 2'b11;
    stim_sof[0] = with_sof;
  endtask

  task automatic run_stim(input int n);
    logic ov, ob;
    dec.delete();
    dec_k.delete();
    gap_pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, stim[i], stim_sof[i], ov, ob);
      if (ov) begin
        dec.push_back(ob);
        dec_k.push_back(i);
      end
      for (int g = 0; g < gap_after[i]; g++) begin
        step(1'b0, 2'b00, 1'b0, ov, ob);
        if (ov) gap_pulses++;
      end
    end
    step(1'b0, 2'b00, 1'b0, ov, ob);
    if (ov) gap_pulses++;
  endtask

  task automatic check_ref_decode(input string name);
    int first;
    logic got;
    first = (dec_k.size() > 0) ? dec_k[0] : -1;
    checks++;
    if (dec.size() !== 6) begin
      errors++;
      $display("FAIL %s_count: got %0d pulses, expected 6", name, dec.size());
    end
    checks++;
    if (first !== 14) begin
      errors++;
      $display("FAIL %s_first: first pulse after symbol %0d, expected 14", name, first);
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < dec.size()) ? dec[i] : 1'bx;
      checks++;
      if (got !== exp_bits[i]) begin
        errors++;
        $display("FAIL %s_bit%0d: got %b expected %b", name, i, got, exp_bits[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic ov, ob;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_bit !== 1'b0) begin
      errors++;
      $display("FAIL reset_bit: got %b expected 0", out_bit);
    end
    step(1'b1, 2'b11, 1'b1, ov, ob);
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_valid: got %b expected 0", ov);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic test_zeros();
    logic ov, ob;
    int pulses = 0;
    int bad_bits = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 2'b00, (k == 0), ov, ob);
      checks++;
      if (ov !== (k >= 14)) begin
        errors++;
        $display("FAIL zeros_valid_k%0d: got %b expected %b", k, ov, (k >= 14));
      end
      if (ov === 1'b1) begin
        pulses++;
        if (ob !== 1'b0) bad_bits++;
      end
    end
    step(1'b0, 2'b00, 1'b0, ov, ob);
    checks++;
    if (pulses !== 26) begin
      errors++;
      $display("FAIL zeros_count: got %0d expected 26", pulses);
    end
    checks++;
    if (bad_bits !== 0) begin
      errors++;
      $display("FAIL zeros_bits: got %0d nonzero bits expected 0", bad_bits);
    end
  endtask

  task automatic test_basic();
    load_ref(1'b0, 1'b1);
    run_stim(20);
    check_ref_decode("basic");
  endtask

  task automatic test_bit_error();
    load_ref(1'b1, 1'b1);
    run_stim(20);
    check_ref_decode("biterr");
  endtask

  task automatic test_gaps();
    load_ref(1'b0, 1'b1);
    gap_after[3]  = 3;
    gap_after[15] = 3;
    run_stim(20);
    checks++;
    if (gap_pulses !== 0) begin
      errors++;
      $display("FAIL gaps_idle_valid: got %0d pulses expected 0", gap_pulses);
    end
    check_ref_decode("gaps");
  endtask

  task automatic test_reset_midframe();
    logic ov, ob;
    clear_stim();
    for (int i = 0; i < 8; i++) stim[i] = 2'(i * 3 + 1);
    stim_sof[0] = 1'b1;
    run_stim(8);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    load_ref(1'b0, 1'b0);
    run_stim(20);
    check_ref_decode("midreset");
    step(1'b0, 2'b00, 1'b0, ov, ob);
  endtask

  task automatic test_sof_midstream();
    clear_stim();
    for (int i = 0; i < 18; i++) stim[i] = 2'(i + 2);
    stim_sof[0] = 1'b1;
    run_stim(18);
    checks++;
    if (dec.size() !== 4) begin
      errors++;
      $display("FAIL sof_prev_count: got %0d expected 4", dec.size());
    end
    load_ref(1'b0, 1'b1);
    run_stim(20);
    check_ref_decode("sofmid");
  endtask

  task automatic test_async_reset();
    logic ov, ob;
    load_ref(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, stim[i], stim_sof[i], ov, ob);
    checks++;
    if (ov !== 1'b1 || ob !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got valid=%b bit=%b expected valid=1 bit=1", ov, ob);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bit !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b bit=%b expected 0 0", out_valid, out_bit);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
  endtask

  initial begin
    exp_bits[0] = 1'b1;
    exp_bits[1] = 1'b0;
    exp_bits[2] = 1'b1;
    exp_bits[3] = 1'b1;
    exp_bits[4] = 1'b0;
    exp_bits[5] = 1'b0;
    in_valid = 1'b0;
    c        = 2'b00;
    sof      = 1'b0;
    test_reset();
    test_zeros();
    test_basic();
    test_bit_error();
    test_gaps();
    test_reset_midframe();
    test_sof_midstream();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
